cfg_axil_write_seq: RTL and testbench

- Downstream consumer of the configuration-register controller's latched register bank and start edge.
- On a start pulse, snapshots a bank of N_WORDS 32-bit registers and replays the enabled words as single-beat AXI4-Lite writes to consecutive addresses on the SAURIA/DMA configuration ports.
- When every write has been acknowledged, it reports completion plus the first error response back to the controller's done/interrupt logic.

---
 rtl/cfg_axil_write_seq.sv | 165 ++++++++++++++++
 tb/tb_cfg_axil_write_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_axil_write_seq.sv
// cfg_axil_write_seq: snapshots a register bank on start and replays the enabled
// words as single-beat AXI4-Lite writes to consecutive addresses, then reports done/error.
`default_nettype none

module cfg_axil_write_seq #(
    parameter int N_WORDS    = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [N_WORDS*32-1:0]   regs_i,
    input  logic [N_WORDS-1:0]      en_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [5:0]              err_idx_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [2:0]              awprot_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    output logic [31:0]             wdata_o,
    output logic [3:0]              wstrb_o,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    input  logic [1:0]              bresp_i
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_B = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [31:0]             regs_snap_q [N_WORDS];
    logic [N_WORDS-1:0]      en_snap_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [5:0]              err_idx_q;
    logic                    awvalid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic                    wvalid_q;
    logic [31:0]             wdata_q;
    logic                    bready_q;

    logic [IDX_W-1:0]        idx_inc;
    logic                    last_word;
    logic                    aw_done;
    logic                    w_done;
    logic                    advance;

    assign idx_inc   = idx_q + 1'b1;
    assign last_word = (idx_q == IDX_W'(N_WORDS - 1));
    // A channel counts as done once its valid has dropped or it handshakes this cycle.
    assign aw_done   = !awvalid_q || awready_i;
    assign w_done    = !wvalid_q  || wready_i;
    assign advance   = ((state_q == S_ISSUE) && !en_snap_q[idx_q]) ||
                       ((state_q == S_WAIT_B) && bvalid_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            en_snap_q <= '0;
            for (int k = 0; k < N_WORDS; k++) begin
                regs_snap_q[k] <= '0;
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        for (int k = 0; k < N_WORDS; k++) begin
                            regs_snap_q[k] <= regs_i[32*k +: 32];
                        end
                        en_snap_q <= en_i;
                        err_q     <= 1'b0;
                        err_idx_q <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        // Word 0 is presented straight from the inputs being snapshotted.
                        awvalid_q <= en_i[0];
                        wvalid_q  <= en_i[0];
                        awaddr_q  <= base_addr_i;
                        wdata_q   <= regs_i[31:0];
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (en_snap_q[idx_q]) begin
                        if (awvalid_q && awready_i) awvalid_q <= 1'b0;
                        if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
                        if (aw_done && w_done) begin
                            bready_q <= 1'b1;
                            state_q  <= S_WAIT_B;
                        end
                    end
                end
                S_WAIT_B: begin
                    if (bvalid_i) begin
                        bready_q <= 1'b0;
                        if ((bresp_i != 2'b00) && !err_q) begin
                            err_q     <= 1'b1;
                            err_idx_q <= 6'(idx_q);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (advance) begin
                if (last_word) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    idx_q     <= idx_inc;
                    awvalid_q <= en_snap_q[idx_inc];
                    wvalid_q  <= en_snap_q[idx_inc];
                    awaddr_q  <= awaddr_q + ADDR_WIDTH'(4);
                    wdata_q   <= regs_snap_q[idx_inc];
                    state_q   <= S_ISSUE;
                end
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign err_idx_o = err_idx_q;
    assign awvalid_o = awvalid_q;
    assign awaddr_o  = awaddr_q;
    assign awprot_o  = 3'b000;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = 4'hF;
    assign bready_o  = bready_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_axil_write_seq.sv
// Bench for cfg_axil_write_seq: responsive AXI4-Lite slave with programmable delays,
// directed scenarios plus randomized sequences checked against a transaction-list model.
`default_nettype none
`timescale 1ns/1ps

module tb_cfg_axil_write_seq;

    localparam int N  = 4;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [N*32-1:0]   regs_i = '0;
    logic [N-1:0]      en_i = '0;
    logic [AW-1:0]     base_addr_i = '0;
    logic              busy_o, done_o, err_o;
    logic [5:0]        err_idx_o;
    logic              awvalid_o, wvalid_o, bready_o;
    logic              awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0;
    logic [AW-1:0]     awaddr_o;
    logic [2:0]        awprot_o;
    logic [31:0]       wdata_o;
    logic [3:0]        wstrb_o;
    logic [1:0]        bresp_i = 2'b00;

    cfg_axil_write_seq #(.N_WORDS(N), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .regs_i(regs_i), .en_i(en_i),
        .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_idx_o(err_idx_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .awaddr_o(awaddr_o), .awprot_o(awprot_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .bresp_i(bresp_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave configuration and observed traffic
    int          aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0]  bresp_plan [N];
    logic [AW-1:0] slv_base = '0;
    logic [AW-1:0] got_addr [$];
    logic [31:0]   got_data [$];
    int          done_cnt = 0;
    int          proto_err = 0;

    initial begin : g_slave
        int aw_cnt, w_cnt, b_cnt, cur_word;
        bit aw_got, w_got, b_fire, aw_stall, w_stall, aw_hs, w_hs;
        logic [AW-1:0] prev_addr;
        logic [31:0]   prev_data;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; cur_word = 0;
        aw_got = 0; w_got = 0; b_fire = 0; aw_stall = 0; w_stall = 0; aw_hs = 0; w_hs = 0;
        prev_addr = '0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 2'b00;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                aw_got = 0; w_got = 0; b_fire = 0; aw_stall = 0; w_stall = 0; aw_hs = 0; w_hs = 0;
            end else begin
                // Payload must hold while stalled; valid must drop right after its handshake.
                if (aw_stall && (!awvalid_o || awaddr_o !== prev_addr)) proto_err++;
                if (w_stall && (!wvalid_o || wdata_o !== prev_data))    proto_err++;
                if (aw_hs && awvalid_o) proto_err++;
                if (w_hs && wvalid_o)   proto_err++;
                if (b_fire) begin
                    bvalid_i = 0; aw_got = 0; w_got = 0; b_fire = 0; b_cnt = 0;
                end
                if (aw_got && w_got && !bvalid_i) begin
                    if (b_cnt >= b_dly) begin
                        bvalid_i = 1;
                        bresp_i  = (cur_word >= 0 && cur_word < N) ? bresp_plan[cur_word] : 2'b00;
                    end else begin
                        b_cnt++;
                    end
                end
                if (bvalid_i && bready_o) b_fire = 1;
                if (awvalid_o) begin awready_i = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin awready_i = 0; aw_cnt = 0; end
                if (wvalid_o) begin wready_i = (w_cnt >= w_dly); w_cnt++; end
                else begin wready_i = 0; w_cnt = 0; end
                aw_hs = awvalid_o && awready_i;
                w_hs  = wvalid_o && wready_i;
                if (aw_hs) begin
                    if (aw_got) proto_err++;
                    got_addr.push_back(awaddr_o);
                    aw_got = 1;
                    cur_word = int'((awaddr_o - slv_base) >> 2);
                end
                if (w_hs) begin
                    if (w_got) proto_err++;
                    got_data.push_back(wdata_o);
                    w_got = 1;
                end
                aw_stall = awvalid_o && !awready_i;
                w_stall  = wvalid_o && !wready_i;
                prev_addr = awaddr_o;
                prev_data = wdata_o;
                if (done_o) done_cnt++;
            end
        end
    end

    task automatic run_seq(input string name, input logic [N*32-1:0] regs, input logic [N-1:0] en,
                           input logic [AW-1:0] base, input int ad, input int wd, input int bd,
                           input logic [2*N-1:0] plan, input bit chk_lat, input bit restart);
        logic [AW-1:0] ea [$];
        logic [31:0]   ed [$];
        int  n_en, e_idx, span, t0, waited, n_cmp;
        bit  e_err;
        n_en = 0; e_err = 0; e_idx = 0;
        for (int k = 0; k < N; k++) begin
            if (en[k]) begin
                ea.push_back(base + AW'(4 * k));
                ed.push_back(regs[32*k +: 32]);
                n_en++;
                if (!e_err && plan[2*k +: 2] != 2'b00) begin e_err = 1; e_idx = k; end
            end
        end
        // Inclusive span from the start cycle to the done cycle with a zero-wait slave.
        span = 2 * n_en + (N - n_en) + 2;
        aw_dly = ad; w_dly = wd; b_dly = bd; slv_base = base;
        for (int k = 0; k < N; k++) bresp_plan[k] = plan[2*k +: 2];
        got_addr.delete(); got_data.delete();
        done_cnt = 0; proto_err = 0;

        @(negedge clk);
        regs_i = regs; en_i = en; base_addr_i = base; start_i = 1'b1; t0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
        regs_i = {$urandom, $urandom, $urandom, $urandom};
        en_i = ~en;
        base_addr_i = $urandom;
        chk({name, ".busy"}, 64'(busy_o), 64'd1);
        chk({name, ".err_clr"}, 64'(err_o), 64'd0);
        if (restart) begin
            repeat (2) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        waited = 0;
        while (!done_o && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk({name, ".done_seen"}, 64'(done_o), 64'd1);
        if (chk_lat) chk({name, ".latency"}, 64'(cyc - t0 + 1), 64'(span));
        chk({name, ".busy_at_done"}, 64'(busy_o), 64'd0);
        chk({name, ".err"}, 64'(err_o), 64'(e_err));
        chk({name, ".err_idx"}, 64'(err_idx_o), 64'(e_idx));
        repeat (4) @(negedge clk);
        chk({name, ".done_cnt"}, 64'(done_cnt), 64'd1);
        chk({name, ".n_aw"}, 64'(got_addr.size()), 64'(n_en));
        chk({name, ".n_w"}, 64'(got_data.size()), 64'(n_en));
        n_cmp = (got_addr.size() < n_en) ? got_addr.size() : n_en;
        for (int i = 0; i < n_cmp; i++) chk({name, ".addr"}, 64'(got_addr[i]), 64'(ea[i]));
        n_cmp = (got_data.size() < n_en) ? got_data.size() : n_en;
        for (int i = 0; i < n_cmp; i++) chk({name, ".data"}, 64'(got_data[i]), 64'(ed[i]));
        chk({name, ".protocol"}, 64'(proto_err), 64'd0);
        chk({name, ".err_hold"}, 64'(err_o), 64'(e_err));
    endtask

    initial begin : g_main
        logic [N*32-1:0] dregs;
        logic [N*32-1:0] rregs;
        logic [2*N-1:0]  rplan;
        logic [AW-1:0]   rbase;
        int ad, wd, bd;
        dregs = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        for (int k = 0; k < N; k++) bresp_plan[k] = 2'b00;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy_o), 64'd0);
        chk("rst.done", 64'(done_o), 64'd0);
        chk("rst.err", 64'(err_o), 64'd0);
        chk("rst.err_idx", 64'(err_idx_o), 64'd0);
        chk("rst.valids", 64'({awvalid_o, wvalid_o, bready_o}), 64'd0);
        chk("const.awprot", 64'(awprot_o), 64'd0);
        chk("const.wstrb", 64'(wstrb_o), 64'hF);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq("all_en",   dregs, 4'b1111, 32'h100, 0, 0, 0, 8'h00, 1, 0);
        run_seq("en_0101",  dregs, 4'b0101, 32'h100, 0, 0, 0, 8'h00, 1, 0);
        run_seq("delayed",  dregs, 4'b1111, 32'h100, 3, 1, 0, 8'h00, 0, 0);
        run_seq("slverr",   dregs, 4'b1111, 32'h100, 0, 0, 0, 8'b10_00_10_00, 1, 0);
        run_seq("err_clr",  dregs, 4'b1111, 32'h100, 0, 0, 0, 8'h00, 1, 0);
        run_seq("restart",  dregs, 4'b1011, 32'h200, 0, 0, 1, 8'h00, 0, 1);
        run_seq("none_en",  dregs, 4'b0000, 32'h100, 0, 0, 0, 8'hFF, 1, 0);
        run_seq("wrap",     dregs, 4'b1111, 32'hFFFF_FFF8, 1, 2, 1, 8'b00_01_00_00, 0, 0);

        // Reset while a write is stalled on AW.
        aw_dly = 6; w_dly = 0; b_dly = 0; slv_base = 32'h100;
        @(negedge clk);
        regs_i = dregs; en_i = 4'b1111; base_addr_i = 32'h100; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("midrst.aw_pending", 64'(awvalid_o), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.valids", 64'({awvalid_o, wvalid_o, bready_o}), 64'd0);
        chk("midrst.status", 64'({busy_o, done_o, err_o}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_seq("post_rst", dregs, 4'b1111, 32'h100, 0, 0, 0, 8'h00, 1, 0);

        for (int t = 0; t < 10; t++) begin
            rregs = {$urandom, $urandom, $urandom, $urandom};
            rbase = {$urandom_range(0, 32'hFFFF_FFFF)} & ~32'h3;
            ad = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            bd = $urandom_range(0, 2);
            for (int k = 0; k < N; k++)
                rplan[2*k +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_seq("rand", rregs, 4'($urandom), rbase, ad, wd, bd, rplan,
                    (ad == 0 && wd == 0 && bd == 0), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
